// File: rtl/correlator_multi_pkg.sv
// Shared constants for the multi-pair correlator: FSM encoding, header widths and field order.
// Field order is also the order in which counts appear in each pair's packet section.
package correlator_multi_pkg;

    localparam int BYTE_W    = 8;
    localparam int DROPCNT_W = 7;
    localparam int N_FLDS    = 4;

    localparam int FLD_X       = 0;
    localparam int FLD_Y       = 1;
    localparam int FLD_ISECT   = 2;
    localparam int FLD_SYMDIFF = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR0 = 2'd1;
    localparam logic [1:0] ST_HDR1 = 2'd2;
    localparam logic [1:0] ST_BODY = 2'd3;

endpackage

// File: rtl/correlator_multi_if.sv
// Sample/config inputs plus the outbound byte stream of correlator_multi.
// The master side drives samples and ready; the slave side (the correlator) drives the stream.
interface correlator_multi_if
    import correlator_multi_pkg::*;
#(
    parameter int N_PAIRS = 4,
    parameter int TIME_W  = 16
);
    localparam int EXP_W = $clog2(TIME_W + 1);

    logic                cg;
    logic                sample_strobe;
    logic [N_PAIRS-1:0]  x;
    logic [N_PAIRS-1:0]  y;
    logic [EXP_W-1:0]    window_length_exp;
    logic [N_PAIRS-1:0]  pair_mask;
    logic [BYTE_W-1:0]   data;
    logic                valid;
    logic                ready;
    logic                busy;

    modport master (
        output cg, sample_strobe, x, y, window_length_exp, pair_mask, ready,
        input  data, valid, busy
    );

    modport slave (
        input  cg, sample_strobe, x, y, window_length_exp, pair_mask, ready,
        output data, valid, busy
    );

endinterface

// File: rtl/corr_pair_rect.sv
// One x/y pair's saturating X, Y, Isect and Symdiff window counters.
// rpt carries the MS bytes of the counts as they will be after this cycle's sample.
module corr_pair_rect
    import correlator_multi_pkg::*;
#(
    parameter int TIME_W = 16,
    parameter int RPT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          strobe,
    input  logic                          x,
    input  logic                          y,
    output logic [N_FLDS-1:0][RPT_W-1:0]  rpt
);

    logic [N_FLDS-1:0][TIME_W-1:0] cnt;
    logic [N_FLDS-1:0][TIME_W-1:0] cnt_upd;
    logic [N_FLDS-1:0]             bits;

    assign bits[FLD_X]       = x;
    assign bits[FLD_Y]       = y;
    assign bits[FLD_ISECT]   = x & y;
    assign bits[FLD_SYMDIFF] = x ^ y;

    always_comb begin
        for (int f = 0; f < N_FLDS; f++) begin
            cnt_upd[f] = cnt[f];
            if (strobe && bits[f] && (cnt[f] != '1))
                cnt_upd[f] = cnt[f] + TIME_W'(1);
            rpt[f] = cnt_upd[f][TIME_W-1 -: RPT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= clear ? '0 : cnt_upd;
    end

endmodule

// File: rtl/correlator_multi.sv
// N_PAIRS windowed x/y correlators; each window's counts are snapshotted and sent as a byte packet.
// Windows ending while a packet is still draining are dropped and counted in the next header.
module correlator_multi
    import correlator_multi_pkg::*;
#(
    parameter int N_PAIRS     = 4,
    parameter int TIME_W      = 16,
    parameter int COUNT_BYTES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    correlator_multi_if.slave bus
);

    localparam int EW = $clog2(TIME_W + 1);
    localparam int RW = 8 * COUNT_BYTES;
    localparam int PW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int BW = (COUNT_BYTES > 1) ? $clog2(COUNT_BYTES) : 1;

    logic [EW-1:0]                          exp_q;
    logic [TIME_W-1:0]                      t;
    logic [TIME_W-1:0]                      t_last;
    logic [TIME_W:0]                        win_len;
    logic [7:0]                             win_num;
    logic [DROPCNT_W-1:0]                   drop_cnt;
    logic                                   cfg_chg;
    logic                                   wrap;
    logic                                   accept;

    logic [N_PAIRS-1:0][N_FLDS-1:0][RW-1:0] rpt;
    logic [N_PAIRS-1:0][N_FLDS-1:0][RW-1:0] snap_rpt;
    logic [N_PAIRS-1:0]                     snap_mask;
    logic [7:0]                             snap_win;
    logic [DROPCNT_W-1:0]                   snap_drop;

    logic [1:0]                             state;
    logic [PW-1:0]                          pair_idx;
    logic [1:0]                             fld;
    logic [BW-1:0]                          byte_idx;
    logic [PW-1:0]                          nxt_pair;
    logic                                   nxt_found;
    logic [RW-1:0]                          body_word;
    logic [RW-1:0]                          body_sh;
    logic [BYTE_W-1:0]                      data_c;

    assign win_len = (TIME_W+1)'(1) << bus.window_length_exp;
    assign t_last  = TIME_W'(win_len - (TIME_W+1)'(1));
    // A config change restarts the window and wins over a coincident wrap.
    assign cfg_chg = (bus.window_length_exp != exp_q);
    assign wrap    = bus.sample_strobe && (t == t_last) && !cfg_chg;
    assign accept  = bus.valid && bus.ready;

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        corr_pair_rect #(.TIME_W(TIME_W), .RPT_W(RW)) u_pair (
            .clk    (i_clk),
            .rst    (i_rst),
            .en     (bus.cg),
            .clear  (cfg_chg || wrap),
            .strobe (bus.sample_strobe),
            .x      (bus.x[p]),
            .y      (bus.y[p]),
            .rpt    (rpt[p])
        );
    end

    // Next masked pair after the current one (first masked pair when leaving HDR1).
    always_comb begin
        nxt_found = 1'b0;
        nxt_pair  = '0;
        for (int p = N_PAIRS - 1; p >= 0; p--) begin
            if (snap_mask[p] && ((state == ST_HDR1) || (p > int'(pair_idx)))) begin
                nxt_found = 1'b1;
                nxt_pair  = PW'(p);
            end
        end
    end

    always_comb begin
        body_word = snap_rpt[pair_idx][fld];
        body_sh   = body_word >> (8 * (COUNT_BYTES - 1 - int'(byte_idx)));
        case (state)
            ST_HDR0: data_c = snap_win;
            ST_HDR1: data_c = {snap_drop != '0, snap_drop};
            ST_BODY: data_c = body_sh[BYTE_W-1:0];
            default: data_c = '0;
        endcase
    end

    assign bus.data  = data_c;
    assign bus.valid = (state != ST_IDLE);
    assign bus.busy  = (state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exp_q     <= '0;
            t         <= '0;
            win_num   <= '0;
            drop_cnt  <= '0;
            snap_rpt  <= '0;
            snap_mask <= '0;
            snap_win  <= '0;
            snap_drop <= '0;
            state     <= ST_IDLE;
            pair_idx  <= '0;
            fld       <= '0;
            byte_idx  <= '0;
        end else if (bus.cg) begin
            exp_q <= bus.window_length_exp;
            if (cfg_chg)
                t <= '0;
            else if (bus.sample_strobe)
                t <= wrap ? '0 : t + TIME_W'(1);

            if (wrap) begin
                win_num <= win_num + 8'd1;
                if (state == ST_IDLE) begin
                    snap_rpt  <= rpt;
                    snap_mask <= bus.pair_mask;
                    snap_win  <= win_num;
                    snap_drop <= drop_cnt;
                    drop_cnt  <= '0;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROPCNT_W'(1);
                end
            end

            case (state)
                ST_IDLE: if (wrap) state <= ST_HDR0;
                ST_HDR0: if (accept) state <= ST_HDR1;
                ST_HDR1: begin
                    if (accept) begin
                        pair_idx <= nxt_pair;
                        fld      <= '0;
                        byte_idx <= '0;
                        state    <= nxt_found ? ST_BODY : ST_IDLE;
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        if (byte_idx != BW'(COUNT_BYTES - 1)) begin
                            byte_idx <= byte_idx + BW'(1);
                        end else begin
                            byte_idx <= '0;
                            if (fld != 2'(FLD_SYMDIFF)) begin
                                fld <= fld + 2'd1;
                            end else begin
                                fld <= '0;
                                if (nxt_found)
                                    pair_idx <= nxt_pair;
                                else
                                    state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_correlator_multi.sv
// Bench for correlator_multi: directed packet scenarios plus randomized traffic against a
// window/packet reference model that predicts every stream byte and the valid/busy flags.
module tb_correlator_multi;

    localparam int NP     = 4;
    localparam int TW     = 16;
    localparam int CB     = 1;
    localparam int MAXC   = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    correlator_multi_if #(.N_PAIRS(NP), .TIME_W(TW)) bus ();

    correlator_multi #(.N_PAIRS(NP), .TIME_W(TW), .COUNT_BYTES(CB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_cnt [NP][4];
    int          m_t;
    int          m_expq;
    int          m_win;
    int          m_drop;
    byte unsigned m_q [$];
    byte unsigned rx [$];

    byte unsigned pb_exp [10] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
                                  8'h01, 8'h01, 8'h01, 8'h00};
    byte unsigned pair_ff [4] = '{8'h01, 8'h01, 8'h01, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++)
            for (int f = 0; f < 4; f++)
                m_cnt[p][f] = 0;
        m_t = 0; m_expq = 0; m_win = 0; m_drop = 0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit busy0, acc, xb, yb;
        int e, v;
        int inc [4];
        if (!bus.cg) return;
        busy0 = (m_q.size() != 0);
        acc   = busy0 && bus.ready;
        e     = int'(bus.window_length_exp);
        if (e != m_expq) begin
            for (int p = 0; p < NP; p++)
                for (int f = 0; f < 4; f++)
                    m_cnt[p][f] = 0;
            m_t = 0;
        end else if (bus.sample_strobe) begin
            for (int p = 0; p < NP; p++) begin
                xb = bus.x[p]; yb = bus.y[p];
                inc[0] = int'(xb); inc[1] = int'(yb);
                inc[2] = int'(xb & yb); inc[3] = int'(xb ^ yb);
                for (int f = 0; f < 4; f++)
                    if (m_cnt[p][f] + inc[f] <= MAXC) m_cnt[p][f] += inc[f];
            end
            if (m_t == (1 << e) - 1) begin
                if (!busy0) begin
                    m_q.push_back(8'(m_win));
                    m_q.push_back(8'((m_drop != 0 ? 128 : 0) + m_drop));
                    for (int p = 0; p < NP; p++) begin
                        if (bus.pair_mask[p]) begin
                            for (int f = 0; f < 4; f++) begin
                                v = m_cnt[p][f];
                                for (int b = 0; b < CB; b++)
                                    m_q.push_back(8'((v >> (TW - 8 * (b + 1))) & 255));
                            end
                        end
                    end
                    m_drop = 0;
                end else if (m_drop < 127) begin
                    m_drop++;
                end
                m_win = (m_win + 1) % 256;
                for (int p = 0; p < NP; p++)
                    for (int f = 0; f < 4; f++)
                        m_cnt[p][f] = 0;
                m_t = 0;
            end else begin
                m_t++;
            end
        end
        m_expq = e;
        if (acc) void'(m_q.pop_front());
    endfunction

    // Called just after a falling edge with inputs already applied for the coming rising edge.
    task automatic tick();
        check("valid", 32'(bus.valid), 32'(m_q.size() != 0));
        check("busy", 32'(bus.busy), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("data", 32'(bus.data), 32'(m_q[0]));
        if (bus.cg && bus.valid && bus.ready) rx.push_back(bus.data);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input int e, input int xv, input int yv, input int mask, input bit rdy);
        bus.cg                = 1'b1;
        bus.sample_strobe     = 1'b1;
        bus.window_length_exp = 5'(e);
        bus.x                 = 4'(xv);
        bus.y                 = 4'(yv);
        bus.pair_mask         = 4'(mask);
        bus.ready             = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rx.delete();
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1'b0);
        bus.cg = 1'b0;
        bus.sample_strobe = 1'b0;
        do_reset();
        check("rst_busy", 32'(bus.busy), 32'h0);

        // All pairs x=y=1, 256-sample windows: three 18-byte packets, HDR0 0,1,2.
        set_in(8, 'hF, 'hF, 'hF, 1'b1);
        repeat (800) tick();
        check("a_len", 32'(rx.size()), 32'd54);
        for (int k = 0; k < 3; k++) begin
            check("a_hdr0", 32'(rx[18*k]), 32'(k));
            check("a_hdr1", 32'(rx[18*k+1]), 32'h0);
            for (int i = 0; i < 16; i++)
                check("a_body", 32'(rx[18*k+2+i]), 32'(pair_ff[i % 4]));
        end

        // Sparse mask: pairs 0 and 2 only.
        do_reset();
        set_in(8, 'b0101, 'b0100, 'b0101, 1'b1);
        repeat (300) tick();
        check("b_len", 32'(rx.size()), 32'd10);
        for (int i = 0; i < 10; i++) check("b_byte", 32'(rx[i]), 32'(pb_exp[i]));

        // Stall across three window ends: next header reports three drops.
        do_reset();
        set_in(5, 'hF, 'hF, 'hF, 1'b1);
        for (int c = 0; c < 215; c++) begin
            bus.ready = (c < 20) || (c >= 140);
            tick();
        end
        check("c_len", 32'(rx.size()), 32'd54);
        check("c_hdr0_a", 32'(rx[0]), 32'h00);
        check("c_hdr1_a", 32'(rx[1]), 32'h00);
        check("c_hdr0_b", 32'(rx[18]), 32'h04);
        check("c_hdr1_b", 32'(rx[19]), 32'h83);
        check("c_hdr0_c", 32'(rx[36]), 32'h05);
        check("c_hdr1_c", 32'(rx[37]), 32'h00);

        // Window length change mid-window restarts counting without a packet.
        do_reset();
        set_in(9, 'h1, 'h1, 'h1, 1'b1);
        repeat (300) tick();
        check("d_nopkt", 32'(rx.size()), 32'd0);
        bus.window_length_exp = 5'd8;
        repeat (300) tick();
        check("d_len", 32'(rx.size()), 32'd6);
        check("d_hdr0", 32'(rx[0]), 32'h00);
        check("d_x", 32'(rx[2]), 32'h01);
        check("d_sd", 32'(rx[5]), 32'h00);

        // Every strobe ends a window while stalled: drop count saturates.
        do_reset();
        set_in(0, 'hF, 'hA, 'hF, 1'b0);
        repeat (200) tick();
        bus.ready = 1'b1;
        repeat (40) tick();
        check("g_hdr1_sat", 32'(rx[19]), 32'hFF);

        // Asynchronous reset in the middle of a pending packet.
        do_reset();
        set_in(2, 'hF, 'hF, 'hF, 1'b0);
        repeat (10) tick();
        check("f_pre_valid", 32'(bus.valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("f_async_valid", 32'(bus.valid), 32'h0);
        check("f_async_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rx.delete();
        bus.ready = 1'b1;
        repeat (12) tick();
        check("f_hdr0", 32'(rx[0]), 32'h00);

        // Randomized traffic, clock gating and backpressure.
        do_reset();
        set_in(3, 0, 0, 'hF, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            bus.cg            = ($urandom_range(0, 7) != 0);
            bus.sample_strobe = ($urandom_range(0, 3) != 0);
            bus.x             = 4'($urandom);
            bus.y             = 4'($urandom);
            bus.pair_mask     = 4'($urandom);
            bus.ready         = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0)
                bus.window_length_exp = 5'($urandom_range(1, 5));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
